pts_frame_tx: RTL and testbench
===============================

# pts_frame_tx

Parallel-to-serial frame transmitter: the transmit end of the serial link whose receive end is the flexible serial-to-parallel shift register. It accepts one NUM_BITS word per valid/ready handshake and drives it onto a single serial line as a framed bit stream, holding each bit for CLKS_PER_BIT clocks. The frame is a start bit, the data bits (MSB- or LSB-first), and a stop bit. The line idles high, matching the receiver's all-ones reset state.

## Interface
- NUM_BITS, 16, data word width; legal range ≥ 2.
- SHIFT_MSB, 1, 1 = send MSB first, 0 = send LSB first.
- CLKS_PER_BIT, 4, clocks per serial bit period; legal range ≥ 1.
- clk  in  1  single system clock; all logic on the rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- tx_data  in  NUM_BITS  word to send; sampled only on handshake.
- tx_valid  in  1  producer has a word on tx_data.
- tx_ready  out  1  block can accept a word; high only in IDLE.
- serial_out  out  1  registered serial line; idle/stop = 1, start = 0.
- tx_active  out  1  high while a frame is on the line (START through STOP).
- tx_done  out  1  one-cycle registered pulse at frame completion.

## Operation
- FSM states and transitions:
  - IDLE → START on handshake.
  - START → DATA after CLKS_PER_BIT clocks.
  - DATA → STOP after NUM_BITS bit periods (→ PARITY instead, when enabled).
  - STOP → IDLE after CLKS_PER_BIT clocks.
- Handshake: a word is accepted at a rising edge where tx_valid = 1 and tx_ready = 1.
  - tx_data is copied into an internal NUM_BITS shift register at that edge.
  - Later changes to tx_data do not affect the frame.
- tx_valid while tx_ready = 0 is ignored. There is no queueing, and no data is captured.
- Clock counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Bit counter: counts 0..NUM_BITS-1 in DATA.
- The shift register shifts once per DATA bit boundary:
  - SHIFT_MSB = 1: serial_out takes the current bit [NUM_BITS-1]; the register shifts left.
  - SHIFT_MSB = 0: serial_out takes the current bit [0]; the register shifts right.
- serial_out value by state: 1 in IDLE, 0 in START, the data bit in DATA, 1 in STOP.
- tx_active = 1 in every non-IDLE state.
- tx_done = 1 for exactly one clock: the first IDLE cycle after STOP.
- Reset values: serial_out = 1, tx_active = 0, tx_done = 0, tx_ready = 1, state = IDLE, both counters = 0, shift register = all ones.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously). The frame is abandoned and no tx_done is issued.

## Timing
- Handshake at edge k:
  - serial_out = 0 (start bit) from edge k through edge k+CLKS_PER_BIT.
  - Data bit i occupies the window after edge k+(1+i)·CLKS_PER_BIT.
  - The stop bit occupies the window after edge k+(NUM_BITS+1)·CLKS_PER_BIT.
- At edge k+(NUM_BITS+2)·CLKS_PER_BIT:
  - state = IDLE.
  - tx_done = 1 for that single cycle.
  - tx_ready = 1 in that same cycle.
- Back-to-back: the earliest next accept is edge k+(NUM_BITS+2)·CLKS_PER_BIT+1. The minimum inter-frame gap is therefore one clock of serial_out = 1 beyond the stop bit.
- With CLKS_PER_BIT = 1, each bit lasts exactly one clock and there are no extra wait states.
- Accept-to-first-edge latency is 0: the start bit is registered on the accepting edge.

## Configuration
- PTS_FRAME_TX_PARITY_EN defined:
  - An even-parity bit is sent between the last data bit and the stop bit, for CLKS_PER_BIT clocks.
  - Parity value = XOR of the captured word, computed at acceptance.
  - The frame grows to NUM_BITS+3 bit periods, and the tx_done timing shifts by CLKS_PER_BIT.
- Macro undefined: there is no PARITY state and the frame is NUM_BITS+2 bit periods.

## Test plan
All scenarios use NUM_BITS=8, CLKS_PER_BIT=4 unless stated.
- Reset: assert n_rst=0 mid-cycle → serial_out=1, tx_ready=1, tx_active=0, tx_done=0 immediately and held after release.
- SHIFT_MSB=1, send 8'h01 → line 0 (start) ×4 clk, then 0,0,0,0,0,0,0,1 each ×4 clk, then 1 ×4 clk; tx_done pulses once, 40 clk after accept.
- SHIFT_MSB=0, send 8'h01 → after start: 1,0,0,0,0,0,0,0, then stop; tx_done pulses 40 clk after accept.
- Hold tx_valid=1 through the frame with tx_data changing to 8'hFF after accepting 8'h3C:
  - Line carries 8'h3C only.
  - The second word (8'hFF) is accepted exactly 41 clk after the first.
  - The line is 1 for one idle clock between frames.
- Pulse n_rst low during data bit 3 → serial_out=1, tx_active=0 immediately; no tx_done; a new word sent afterward produces a clean full frame.
- PTS_FRAME_TX_PARITY_EN defined:
  - 8'h07 → parity bit 1; 8'h03 → parity bit 0.
  - Parity sits between the last data bit and the stop bit.
  - tx_done arrives 44 clk after accept.

Source files
------------

// File: rtl/pts_frame_tx.sv
// Parallel-to-serial framed transmitter: start bit, NUM_BITS data bits, optional parity, stop bit.
// Optional even-parity bit enabled by defining PTS_FRAME_TX_PARITY_EN.
module pts_frame_tx #(
  parameter int unsigned NUM_BITS     = 16,
  parameter int unsigned SHIFT_MSB    = 1,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NUM_BITS-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                serial_out,
  output logic                tx_active,
  output logic                tx_done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW = $clog2(NUM_BITS);

  if (NUM_BITS < 2) begin : g_bad_num_bits
    $error("pts_frame_tx: NUM_BITS must be >= 2");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
    $error("pts_frame_tx: CLKS_PER_BIT must be >= 1");
  end

`ifdef PTS_FRAME_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e              state_q;
  logic [CntW-1:0]     clk_cnt_q;
  logic [BitW-1:0]     bit_cnt_q;
  logic [NUM_BITS-1:0] shreg_q;
`ifdef PTS_FRAME_TX_PARITY_EN
  logic                parity_q;
`endif

  logic                bit_end;
  logic                last_bit;
  logic                shreg_head;
  logic [NUM_BITS-1:0] shreg_shifted;

  assign bit_end  = (clk_cnt_q == CntW'(CLKS_PER_BIT - 1));
  assign last_bit = (bit_cnt_q == BitW'(NUM_BITS - 1));

  // Vacated positions fill with ones so the register drifts back to its idle value.
  always_comb begin
    shreg_head    = 1'b1;
    shreg_shifted = shreg_q;
    if (SHIFT_MSB != 0) begin
      shreg_head    = shreg_q[NUM_BITS-1];
      shreg_shifted = {shreg_q[NUM_BITS-2:0], 1'b1};
    end else begin
      shreg_head    = shreg_q[0];
      shreg_shifted = {1'b1, shreg_q[NUM_BITS-1:1]};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= StIdle;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '1;
`ifdef PTS_FRAME_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
      serial_out <= 1'b1;
      tx_active  <= 1'b0;
      tx_done    <= 1'b0;
      tx_ready   <= 1'b1;
    end else begin
      tx_done <= 1'b0;
      if (state_q != StIdle) begin
        clk_cnt_q <= bit_end ? '0 : clk_cnt_q + CntW'(1);
      end

      unique case (state_q)
        StIdle: begin
          // Start bit is registered on the accepting edge: zero-latency frame start.
          if (tx_valid && tx_ready) begin
            state_q    <= StStart;
            shreg_q    <= tx_data;
`ifdef PTS_FRAME_TX_PARITY_EN
            parity_q   <= ^tx_data;
`endif
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            serial_out <= 1'b0;
            tx_active  <= 1'b1;
            tx_ready   <= 1'b0;
          end
        end

        StStart: begin
          if (bit_end) begin
            state_q    <= StData;
            serial_out <= shreg_head;
            shreg_q    <= shreg_shifted;
          end
        end

        StData: begin
          if (bit_end) begin
            if (last_bit) begin
              bit_cnt_q  <= '0;
`ifdef PTS_FRAME_TX_PARITY_EN
              state_q    <= StParity;
              serial_out <= parity_q;
`else
              state_q    <= StStop;
              serial_out <= 1'b1;
`endif
            end else begin
              bit_cnt_q  <= bit_cnt_q + BitW'(1);
              serial_out <= shreg_head;
              shreg_q    <= shreg_shifted;
            end
          end
        end

`ifdef PTS_FRAME_TX_PARITY_EN
        StParity: begin
          if (bit_end) begin
            state_q    <= StStop;
            serial_out <= 1'b1;
          end
        end
`endif

        StStop: begin
          if (bit_end) begin
            state_q    <= StIdle;
            serial_out <= 1'b1;
            tx_active  <= 1'b0;
            tx_ready   <= 1'b1;
            tx_done    <= 1'b1;
          end
        end

        default: begin
          state_q    <= StIdle;
          serial_out <= 1'b1;
          tx_active  <= 1'b0;
          tx_ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pts_frame_tx.sv
// Directed bench for pts_frame_tx: one MSB-first and one LSB-first instance, NUM_BITS=8, CLKS_PER_BIT=4.
// Expectations follow PTS_FRAME_TX_PARITY_EN when it is defined.
module tb_pts_frame_tx;

  localparam int NB  = 8;
  localparam int CPB = 4;
`ifdef PTS_FRAME_TX_PARITY_EN
  localparam int FBITS = NB + 3;
`else
  localparam int FBITS = NB + 2;
`endif
  localparam int FC = FBITS * CPB;

  logic          clk;
  logic          n_rst;
  logic [NB-1:0] data_m, data_l;
  logic          valid_m, valid_l;
  logic          ready_m, ready_l;
  logic          sout_m, sout_l;
  logic          active_m, active_l;
  logic          done_m, done_l;

  int tests;
  int fails;

  pts_frame_tx #(.NUM_BITS(NB), .SHIFT_MSB(1), .CLKS_PER_BIT(CPB)) u_msb (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_data    (data_m),
    .tx_valid   (valid_m),
    .tx_ready   (ready_m),
    .serial_out (sout_m),
    .tx_active  (active_m),
    .tx_done    (done_m)
  );

  pts_frame_tx #(.NUM_BITS(NB), .SHIFT_MSB(0), .CLKS_PER_BIT(CPB)) u_lsb (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_data    (data_l),
    .tx_valid   (valid_l),
    .tx_ready   (ready_l),
    .serial_out (sout_l),
    .tx_active  (active_l),
    .tx_done    (done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level for bit period idx of a frame carrying w.
  function automatic logic frame_bit(input logic [NB-1:0] w, input bit msb, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= NB) return msb ? w[NB-idx] : w[idx-1];
`ifdef PTS_FRAME_TX_PARITY_EN
    if (idx == NB + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  task automatic test_reset();
    #3 n_rst = 1'b0;
    #1;
    tests++;
    if ({sout_m, ready_m, active_m, done_m} !== 4'b1100) begin
      fails++;
      $display("FAIL reset_msb got %b want 1100", {sout_m, ready_m, active_m, done_m});
    end
    tests++;
    if ({sout_l, ready_l, active_l, done_l} !== 4'b1100) begin
      fails++;
      $display("FAIL reset_lsb got %b want 1100", {sout_l, ready_l, active_l, done_l});
    end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({sout_m, ready_m, active_m, done_m, sout_l, ready_l, active_l, done_l} !== 8'b11001100)
    begin
      fails++;
      $display("FAIL reset_hold got %b want 11001100",
               {sout_m, ready_m, active_m, done_m, sout_l, ready_l, active_l, done_l});
    end
  endtask

  task automatic test_msb_first(input logic [NB-1:0] w);
    @(negedge clk);
    data_m  = w;
    valid_m = 1'b1;
    for (int j = 0; j <= FC + 1; j++) begin
      @(negedge clk);
      if (j == 0) begin
        valid_m = 1'b0;
        data_m  = ~w;  // captured word must not follow later input changes
      end
      tests++;
      if (sout_m !== ((j < FC) ? frame_bit(w, 1'b1, j / CPB) : 1'b1)) begin
        fails++;
        $display("FAIL msb_line w=%h j=%0d got %b want %b", w, j, sout_m,
                 (j < FC) ? frame_bit(w, 1'b1, j / CPB) : 1'b1);
      end
      tests++;
      if ({done_m, active_m, ready_m} !== {(j == FC), (j < FC), (j >= FC)}) begin
        fails++;
        $display("FAIL msb_ctrl w=%h j=%0d got done/active/ready=%b want %b", w, j,
                 {done_m, active_m, ready_m}, {(j == FC), (j < FC), (j >= FC)});
      end
    end
  endtask

  task automatic test_lsb_first(input logic [NB-1:0] w);
    @(negedge clk);
    data_l  = w;
    valid_l = 1'b1;
    for (int j = 0; j <= FC + 1; j++) begin
      @(negedge clk);
      if (j == 0) begin
        valid_l = 1'b0;
        data_l  = ~w;
      end
      tests++;
      if (sout_l !== ((j < FC) ? frame_bit(w, 1'b0, j / CPB) : 1'b1)) begin
        fails++;
        $display("FAIL lsb_line w=%h j=%0d got %b want %b", w, j, sout_l,
                 (j < FC) ? frame_bit(w, 1'b0, j / CPB) : 1'b1);
      end
      tests++;
      if ({done_l, active_l, ready_l} !== {(j == FC), (j < FC), (j >= FC)}) begin
        fails++;
        $display("FAIL lsb_ctrl w=%h j=%0d got done/active/ready=%b want %b", w, j,
                 {done_l, active_l, ready_l}, {(j == FC), (j < FC), (j >= FC)});
      end
    end
  endtask

  // tx_valid held high: second word must be accepted one idle clock after tx_done.
  task automatic test_back_to_back();
    logic [NB-1:0] w;
    int            jj;
    @(negedge clk);
    data_m  = 8'h3C;
    valid_m = 1'b1;
    for (int j = 0; j <= 2 * FC + 2; j++) begin
      @(negedge clk);
      if (j == 0) data_m = 8'hFF;
      w  = (j <= FC) ? 8'h3C : 8'hFF;
      jj = (j <= FC) ? j : j - FC - 1;
      tests++;
      if (sout_m !== ((jj < FC) ? frame_bit(w, 1'b1, jj / CPB) : 1'b1)) begin
        fails++;
        $display("FAIL b2b_line j=%0d got %b want %b", j, sout_m,
                 (jj < FC) ? frame_bit(w, 1'b1, jj / CPB) : 1'b1);
      end
      tests++;
      if ({done_m, active_m, ready_m} !== {(jj == FC), (jj < FC), (jj >= FC)}) begin
        fails++;
        $display("FAIL b2b_ctrl j=%0d got done/active/ready=%b want %b", j,
                 {done_m, active_m, ready_m}, {(jj == FC), (jj < FC), (jj >= FC)});
      end
      if (j == FC + 1) valid_m = 1'b0;
    end
  endtask

  task automatic test_reset_mid_frame();
    int done_seen;
    @(negedge clk);
    data_m  = 8'h00;
    valid_m = 1'b1;
    @(negedge clk);
    valid_m = 1'b0;
    // Now just after edge k; move into data bit 3 (window after edge k+4*CPB).
    repeat (4 * CPB + 1) @(negedge clk);
    tests++;
    if (sout_m !== 1'b0) begin
      fails++;
      $display("FAIL mid_pre_line got %b want 0", sout_m);
    end
    n_rst = 1'b0;
    #1;
    tests++;
    if ({sout_m, active_m, ready_m, done_m} !== 4'b1010) begin
      fails++;
      $display("FAIL mid_async got out/active/ready/done=%b want 1010",
               {sout_m, active_m, ready_m, done_m});
    end
    @(negedge clk);
    n_rst     = 1'b1;
    done_seen = 0;
    for (int j = 0; j < FC + 4; j++) begin
      @(negedge clk);
      if (done_m === 1'b1 || sout_m !== 1'b1) done_seen++;
    end
    tests++;
    if (done_seen != 0) begin
      fails++;
      $display("FAIL mid_no_done got %0d bad cycles want 0", done_seen);
    end
  endtask

`ifdef PTS_FRAME_TX_PARITY_EN
  task automatic test_parity();
    logic [NB-1:0] words [2];
    logic          pexp  [2];
    words[0] = 8'h07;
    pexp[0]  = 1'b1;
    words[1] = 8'h03;
    pexp[1]  = 1'b0;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      data_m  = words[t];
      valid_m = 1'b1;
      for (int j = 0; j <= FC + 1; j++) begin
        @(negedge clk);
        if (j == 0) valid_m = 1'b0;
        if (j == (NB + 1) * CPB + 1) begin
          tests++;
          if (sout_m !== pexp[t]) begin
            fails++;
            $display("FAIL parity_bit w=%h got %b want %b", words[t], sout_m, pexp[t]);
          end
        end
        if (j == 44 || j == 40) begin
          tests++;
          if (done_m !== (j == 44)) begin
            fails++;
            $display("FAIL parity_done w=%h j=%0d got %b want %b", words[t], j, done_m, j == 44);
          end
        end
      end
    end
  endtask
`endif

  initial begin
    tests   = 0;
    fails   = 0;
    n_rst   = 1'b1;
    data_m  = '0;
    data_l  = '0;
    valid_m = 1'b0;
    valid_l = 1'b0;

    test_reset();
    test_msb_first(8'h01);
    test_msb_first(8'hA5);
    test_lsb_first(8'h01);
    test_lsb_first(8'hC6);
    test_back_to_back();
    test_reset_mid_frame();
    test_msb_first(8'h5A);  // clean frame after mid-frame reset
`ifdef PTS_FRAME_TX_PARITY_EN
    test_parity();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
